avalon_cmd_master: RTL and testbench
====================================

AVALON_CMD_MASTER -- requirements
Module: avalon_cmd_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, is the number of WAIT cycles allowed for avReadValid before a read is errored.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmdValid  in  1  the upstream command is valid.
REQ-005 cmdReady  out  1  the block can accept a command.
REQ-006 cmdWrite  in  1  1 selects write, 0 selects read.
REQ-007 cmdAddr  in  2  target register address.
REQ-008 cmdData  in  32  write data.
REQ-009 rspValid  out  1  read response is valid.
REQ-010 rspReady  in  1  the consumer accepts the response.
REQ-011 rspData  out  32  read data, or 32'hDEAD_BEEF on timeout.
REQ-012 rspErr  out  1  1 marks a timed-out read.
REQ-013 avRead  out  1  drives the slave read strobe.
REQ-014 avWrite  out  1  drives the slave write strobe.
REQ-015 avAddress  out  2  drives the slave address.
REQ-016 avWriteData  out  32  drives the slave dataIn.
REQ-017 avReadValid  in  1  the slave readValid, one cycle after the read.
REQ-018 avReadData  in  32  the slave dataOut, combinational from avAddress.
REQ-019 irqIn  in  1  the slave irq level.
REQ-020 irqClear  in  1  clears the pending interrupt.
REQ-021 irqPending  out  1  sticky flag for a captured irq rising edge.

Function
REQ-022 The FSM SHALL have states IDLE, WRITE, READ, WAIT and RESP, with one command outstanding at most.
REQ-023 cmdReady SHALL be 1 only in IDLE; a command is accepted on cmdValid&&cmdReady, capturing cmdWrite, cmdAddr and cmdData into registers, then moving to WRITE if cmdWrite=1, else READ.
REQ-024 WRITE: avWrite=1 for exactly one cycle with the captured address and data, then IDLE; writes SHALL produce no response.
REQ-025 READ: avRead=1 for exactly one cycle, the wait timer SHALL clear, then WAIT.
REQ-026 avAddress SHALL hold the captured address from READ through the cycle the response is captured, because slave read data depends on the address.
REQ-027 WAIT: on avReadValid=1, rspData<=avReadData and rspErr<=0, then RESP.
REQ-028 WAIT otherwise: the timer increments; when the timer=TIMEOUT-1 without avReadValid, rspData<=32'hDEAD_BEEF and rspErr<=1, then RESP.
REQ-029 RESP: rspValid=1, with rspData/rspErr held stable until rspReady=1, then IDLE in the next cycle.
REQ-030 Latency, write: accept at cycle N, avWrite at N+1, cmdReady=1 again at N+2.
REQ-031 Latency, read: accept at cycle N, avRead at N+1, avReadValid expected at N+2, rspValid at N+3, cmdReady=1 at the cycle after the response handshake.
REQ-032 avRead and avWrite SHALL never both be 1, and SHALL both be 0 outside READ and WRITE.
REQ-033 avWriteData SHALL be 0 except in WRITE.
REQ-034 avReadValid outside WAIT SHALL be ignored.
REQ-035 The timer SHALL be $clog2(TIMEOUT) bits wide and SHALL not wrap within a single read.
REQ-036 irqPending SHALL set on a cycle where irqIn=1 and the previous-cycle irqIn=0, and SHALL clear on irqClear=1.
REQ-037 When the set and clear conditions coincide, set SHALL win.
REQ-038 irq capture SHALL run independently of the FSM state.

Reset
REQ-039 Reset SHALL force state=IDLE, timer=0, rspData=0, rspErr=0, irqPending=0 and the irqIn history register=0.
REQ-040 During reset, outputs SHALL be cmdReady=0, rspValid=0, avRead=0, avWrite=0, avAddress=0 and avWriteData=0; cmdReady=1 in the first cycle after reset deasserts.
REQ-041 Reset mid-operation SHALL abandon any outstanding command or response with no bus strobe issued afterward; a late avReadValid SHALL be ignored.

Structure
REQ-042 Package avalon_master_pkg SHALL hold the state enum, the DEFAULT_TIMEOUT=16 constant and the TIMEOUT_DATA=32'hDEAD_BEEF constant.
REQ-043 One sub-module, irq_capture, SHALL hold the edge-detect and sticky-flag logic; the FSM and datapath SHALL stay in avalon_cmd_master.

Verification
REQ-044 Write test: write addr=0, data=32'h0000_0010 -> avWrite pulses one cycle with avAddress=0 and avWriteData=32'h10; no rspValid; cmdReady returns at N+2.
REQ-045 Read test: read addr=2 with the slave returning 32'h1 one cycle later -> rspValid at N+3, rspData=32'h1, rspErr=0, avAddress=2 held throughout.
REQ-046 Backpressure test: hold rspReady=0 for 5 cycles -> rspValid and rspData stay stable and cmdReady=0; release -> IDLE the following cycle.
REQ-047 Timeout test: a read that never gets avReadValid -> after 16 WAIT cycles rspData=32'hDEAD_BEEF and rspErr=1.
REQ-048 IRQ test: irqIn rises in the same cycle irqClear=1 -> irqPending=1; then irqClear alone -> 0; irqIn held high -> no re-set.
REQ-049 Reset test: assert reset during WAIT -> next cycle IDLE with all outputs 0, and a subsequent avReadValid produces no rspValid.

Source files
------------

// File: rtl/avalon_master_pkg.sv
// avalon_master_pkg: shared FSM states and constants for the Avalon command master
package avalon_master_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/irq_capture.sv
// irq_capture: rising-edge detect on irqIn with a sticky pending flag, set beats clear
module irq_capture (
  input  logic clk,
  input  logic reset,
  input  logic irqIn,
  input  logic irqClear,
  output logic irqPending
);
  logic r_prev;
  logic r_pending;
  logic w_rise;
  assign w_rise = irqIn & ~r_prev;
  assign irqPending = r_pending;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev <= irqIn;
      r_pending <= w_rise ? 1'b1 : irqClear ? 1'b0 : r_pending;
    end
  end
endmodule

// File: rtl/avalon_cmd_master.sv
// avalon_cmd_master: single-outstanding command bridge onto an Avalon-style slave with read timeout
import avalon_master_pkg::*;
module avalon_cmd_master #(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [1:0]  cmdAddr,
  input  logic [31:0] cmdData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic        avRead,
  output logic        avWrite,
  output logic [1:0]  avAddress,
  output logic [31:0] avWriteData,
  input  logic        avReadValid,
  input  logic [31:0] avReadData,
  input  logic        irqIn,
  input  logic        irqClear,
  output logic        irqPending
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic [1:0] r_addr;
  logic [31:0] r_wdata;
  logic [TW-1:0] r_timer;
  logic [31:0] r_rsp_data;
  logic r_rsp_err;
  logic w_last;
  assign w_last = r_timer == TMAX;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = cmdValid ? (cmdWrite ? WRITE : READ) : IDLE;
      WRITE: w_next = IDLE;
      READ:  w_next = WAIT;
      WAIT:  w_next = (avReadValid || w_last) ? RESP : WAIT;
      RESP:  w_next = rspReady ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are gated by reset so the bus stays quiet during the reset cycle itself
  always_comb begin
    cmdReady = !reset && r_state == IDLE;
    rspValid = !reset && r_state == RESP;
    avWrite = !reset && r_state == WRITE;
    avRead = !reset && r_state == READ;
    avAddress = (!reset && (r_state == WRITE || r_state == READ || r_state == WAIT)) ? r_addr : 2'd0;
    avWriteData = avWrite ? r_wdata : 32'd0;
    rspData = r_rsp_data;
    rspErr = r_rsp_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 2'd0;
      r_wdata <= 32'd0;
      r_timer <= '0;
      r_rsp_data <= 32'd0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == IDLE && cmdValid) begin
        r_addr <= cmdAddr;
        r_wdata <= cmdData;
      end
      if (r_state == READ) r_timer <= '0;
      if (r_state == WAIT) begin
        if (avReadValid) begin
          r_rsp_data <= avReadData;
          r_rsp_err <= 1'b0;
        end else if (w_last) begin
          r_rsp_data <= TIMEOUT_DATA;
          r_rsp_err <= 1'b1;
        end else r_timer <= r_timer + 1'b1;
      end
    end
  end
  irq_capture u_irq (
    .clk(clk),
    .reset(reset),
    .irqIn(irqIn),
    .irqClear(irqClear),
    .irqPending(irqPending)
  );
endmodule

// File: tb/tb_avalon_cmd_master.sv
// tb_avalon_cmd_master: directed plus randomized transactions checked against a memory-map reference model
module tb_avalon_cmd_master;
  localparam int TO = 16;
  logic clk = 0, reset = 1;
  logic cmdValid = 0, cmdReady, cmdWrite = 0;
  logic [1:0] cmdAddr = 0;
  logic [31:0] cmdData = 0;
  logic rspValid, rspReady = 0, rspErr;
  logic [31:0] rspData;
  logic avRead, avWrite, avReadValid = 0;
  logic [1:0] avAddress;
  logic [31:0] avWriteData, avReadData;
  logic irqIn = 0, irqClear = 0, irqPending;
  logic [31:0] slave_mem [4] = '{default: 32'd0};
  logic [31:0] model_mem [4] = '{default: 32'd0};
  int n_cmp = 0, n_bad = 0;

  avalon_cmd_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdData(cmdData), .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspErr(rspErr), .avRead(avRead), .avWrite(avWrite),
    .avAddress(avAddress), .avWriteData(avWriteData), .avReadValid(avReadValid),
    .avReadData(avReadData), .irqIn(irqIn), .irqClear(irqClear), .irqPending(irqPending)
  );

  always #5 clk = ~clk;
  assign avReadData = slave_mem[avAddress];
  always @(posedge clk) if (avWrite) slave_mem[avAddress] <= avWriteData;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, ".avRead"}, 32'(avRead), 0);
    chk({tag, ".avWrite"}, 32'(avWrite), 0);
    chk({tag, ".avWriteData"}, avWriteData, 0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chk("wr.ready_before", 32'(cmdReady), 1);
    cmdValid = 1; cmdWrite = 1; cmdAddr = a; cmdData = d;
    tick;
    cmdValid = 0; cmdWrite = $urandom_range(0, 1); cmdData = $urandom;
    chk("wr.avWrite", 32'(avWrite), 1);
    chk("wr.avRead", 32'(avRead), 0);
    chk("wr.avAddress", 32'(avAddress), 32'(a));
    chk("wr.avWriteData", avWriteData, d);
    chk("wr.cmdReady_busy", 32'(cmdReady), 0);
    chk("wr.rspValid", 32'(rspValid), 0);
    model_mem[a] = d;
    tick;
    chk("wr.cmdReady_back", 32'(cmdReady), 1);
    chk("wr.rspValid_none", 32'(rspValid), 0);
    quiet("wr.after");
  endtask

  // lat: WAIT cycle index at which the slave answers; lat >= TO means it never answers
  task automatic do_read(input logic [1:0] a, input int lat, input int bp);
    logic [31:0] exp_d;
    logic exp_e;
    exp_e = lat >= TO;
    exp_d = exp_e ? 32'hDEAD_BEEF : model_mem[a];
    chk("rd.ready_before", 32'(cmdReady), 1);
    cmdValid = 1; cmdWrite = 0; cmdAddr = a;
    tick;
    cmdValid = 0; cmdAddr = $urandom;
    chk("rd.avRead", 32'(avRead), 1);
    chk("rd.avWrite", 32'(avWrite), 0);
    chk("rd.avAddress_read", 32'(avAddress), 32'(a));
    chk("rd.cmdReady_busy", 32'(cmdReady), 0);
    avReadValid = $urandom_range(0, 1);
    tick;
    for (int w = 0; w < TO; w++) begin
      avReadValid = (w == lat);
      chk("rd.avAddress_wait", 32'(avAddress), 32'(a));
      chk("rd.rspValid_wait", 32'(rspValid), 0);
      quiet("rd.wait");
      tick;
      avReadValid = 0;
      if (w == lat) break;
    end
    for (int b = 0; b <= bp; b++) begin
      rspReady = (b == bp);
      chk("rd.rspValid", 32'(rspValid), 1);
      chk("rd.rspData", rspData, exp_d);
      chk("rd.rspErr", 32'(rspErr), 32'(exp_e));
      chk("rd.cmdReady_resp", 32'(cmdReady), 0);
      tick;
    end
    rspReady = 0;
    chk("rd.cmdReady_back", 32'(cmdReady), 1);
    chk("rd.rspValid_done", 32'(rspValid), 0);
  endtask

  initial begin
    #1;
    tick;
    chk("rst.cmdReady", 32'(cmdReady), 0);
    chk("rst.rspValid", 32'(rspValid), 0);
    chk("rst.avAddress", 32'(avAddress), 0);
    quiet("rst");
    reset = 0;
    tick;
    chk("rst.cmdReady_after", 32'(cmdReady), 1);
    chk("rst.rspData", rspData, 0);
    chk("rst.rspErr", 32'(rspErr), 0);
    chk("rst.irqPending", 32'(irqPending), 0);

    do_write(2'd0, 32'h0000_0010);
    do_write(2'd2, 32'h0000_0001);
    do_read(2'd2, 0, 0);
    do_read(2'd0, 0, 5);
    do_read(2'd1, TO, 0);
    do_read(2'd2, TO - 1, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1)) do_write(2'($urandom), $urandom);
      else do_read(2'($urandom), $urandom_range(0, 9) < 8 ? $urandom_range(0, 4) : TO, $urandom_range(0, 4));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        avReadValid = $urandom_range(0, 1);
        tick;
        avReadValid = 0;
        chk("idle.rspValid", 32'(rspValid), 0);
        chk("idle.cmdReady", 32'(cmdReady), 1);
      end
    end

    irqIn = 1; irqClear = 1;
    tick;
    chk("irq.set_wins", 32'(irqPending), 1);
    tick;
    chk("irq.cleared", 32'(irqPending), 0);
    irqClear = 0;
    tick; tick;
    chk("irq.no_reset_high", 32'(irqPending), 0);
    irqIn = 0;
    tick;
    irqIn = 1;
    tick;
    chk("irq.rise", 32'(irqPending), 1);
    irqIn = 0;
    tick;
    chk("irq.sticky", 32'(irqPending), 1);

    cmdValid = 1; cmdWrite = 0; cmdAddr = 2'd3;
    tick;
    cmdValid = 0;
    tick;
    chk("rstw.in_wait", 32'(avAddress), 3);
    reset = 1;
    #1;
    chk("rstw.cmdReady", 32'(cmdReady), 0);
    chk("rstw.rspValid", 32'(rspValid), 0);
    chk("rstw.avAddress", 32'(avAddress), 0);
    quiet("rstw");
    tick;
    reset = 0;
    chk("rstw.irqPending", 32'(irqPending), 0);
    avReadValid = 1;
    tick;
    avReadValid = 0;
    chk("rstw.cmdReady_after", 32'(cmdReady), 1);
    for (int k = 0; k < 4; k++) begin
      chk("rstw.no_rsp", 32'(rspValid), 0);
      chk("rstw.rspErr", 32'(rspErr), 0);
      quiet("rstw.late");
      tick;
    end
    do_read(2'd3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
